// File: rtl/lock_attempt_controller.sv
// Turns per-attempt unlock/alarm verdicts into timed door, siren and lockout outputs.
// Counts consecutive failures and enforces a lockout window once MAX_FAILS is reached.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  IDLE    | waiting for an attempt; failures accumulate in fail_count
//  OPEN    | door actuator enabled, counting down the open window
//  LOCKOUT | attempts rejected, siren held, counting down the lockout
module lock_attempt_controller #(
    parameter int MAX_FAILS      = 3,
    parameter int OPEN_CYCLES    = 8,
    parameter int LOCKOUT_CYCLES = 16,
    localparam int FW            = $clog2(MAX_FAILS + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          submit,
    input  logic          unlock_in,
    input  logic          alarm_in,
    output logic          door_open,
    output logic          alarm_out,
    output logic          locked_out,
    output logic          attempt_rej,
    output logic [FW-1:0] fail_count
);

    localparam int TMAX = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OPEN    = 2'd1,
        LOCKOUT = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [FW-1:0] fail_d;
    logic          door_d, alarm_d, locked_d, rej_d;
    logic          good;

    assign good = unlock_in & ~alarm_in;

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        fail_d   = fail_count;
        alarm_d  = 1'b0;
        rej_d    = 1'b0;
        door_d   = 1'b0;
        locked_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (submit) begin
                    if (good) begin
                        state_d = OPEN;
                        timer_d = TW'(OPEN_CYCLES - 1);
                        fail_d  = '0;
                    end else if (int'(fail_count) + 1 >= MAX_FAILS) begin
                        state_d = LOCKOUT;
                        timer_d = TW'(LOCKOUT_CYCLES - 1);
                        fail_d  = FW'(MAX_FAILS);
                    end else begin
                        fail_d  = fail_count + 1'b1;
                        alarm_d = 1'b1;
                    end
                end
            end
            OPEN: begin
                rej_d = submit;
                if (timer_q == '0) state_d = IDLE;
                else               timer_d = timer_q - 1'b1;
            end
            LOCKOUT: begin
                rej_d = submit;
                if (timer_q == '0) begin
                    state_d = IDLE;
                    fail_d  = '0;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Outputs are decoded from the next state so they register alongside it.
        door_d   = (state_d == OPEN);
        locked_d = (state_d == LOCKOUT);
        alarm_d  = alarm_d | locked_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            fail_count  <= '0;
            door_open   <= 1'b0;
            alarm_out   <= 1'b0;
            locked_out  <= 1'b0;
            attempt_rej <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            fail_count  <= fail_d;
            door_open   <= door_d;
            alarm_out   <= alarm_d;
            locked_out  <= locked_d;
            attempt_rej <= rej_d;
        end
    end

endmodule

// File: tb/tb_lock_attempt_controller.sv
// Scoreboard bench for lock_attempt_controller: directed scenarios then random attempts,
// expected outputs derived from remaining-window counts and a failure tally.
module tb_lock_attempt_controller;

    localparam int MAX_FAILS      = 3;
    localparam int OPEN_CYCLES    = 8;
    localparam int LOCKOUT_CYCLES = 16;
    localparam int FW             = $clog2(MAX_FAILS + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          submit = 1'b0;
    logic          unlock_in = 1'b0;
    logic          alarm_in = 1'b0;
    logic          door_open, alarm_out, locked_out, attempt_rej;
    logic [FW-1:0] fail_count;

    lock_attempt_controller #(
        .MAX_FAILS     (MAX_FAILS),
        .OPEN_CYCLES   (OPEN_CYCLES),
        .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .submit     (submit),
        .unlock_in  (unlock_in),
        .alarm_in   (alarm_in),
        .door_open  (door_open),
        .alarm_out  (alarm_out),
        .locked_out (locked_out),
        .attempt_rej(attempt_rej),
        .fail_count (fail_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          door;
        logic          alarm;
        logic          locked;
        logic          rej;
        logic [FW-1:0] fc;
        int            cyc;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference: cycles of door/lockout still to be shown, and the failure tally.
    int open_left = 0;
    int lock_left = 0;
    int fails     = 0;
    int cyc       = 0;

    task automatic chk(input string name, input int act, input int exp, input int at);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at step %0d: got %0d expected %0d", name, at, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic s, input logic u, input logic a);
        exp_t e;
        @(negedge clk);
        reset     = r;
        submit    = s;
        unlock_in = u;
        alarm_in  = a;
        e.rej   = 1'b0;
        e.alarm = 1'b0;
        if (r) begin
            open_left = 0;
            lock_left = 0;
            fails     = 0;
        end else if (open_left > 0 || lock_left > 0) begin
            e.rej = s;
            if (open_left > 0) begin
                open_left--;
            end else begin
                lock_left--;
                if (lock_left == 0) fails = 0;
            end
        end else if (s) begin
            if (u && !a) begin
                open_left = OPEN_CYCLES;
                fails     = 0;
            end else begin
                fails++;
                e.alarm = 1'b1;
                if (fails == MAX_FAILS) lock_left = LOCKOUT_CYCLES;
            end
        end
        e.door   = (open_left > 0);
        e.locked = (lock_left > 0);
        if (lock_left > 0) e.alarm = 1'b1;
        e.fc  = FW'(fails);
        e.cyc = cyc;
        cyc++;
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic good();
        step(1'b0, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic bad();
        step(1'b0, 1'b1, 1'b0, 1'b1);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("door_open",   int'(door_open),   int'(e.door),   e.cyc);
                chk("alarm_out",   int'(alarm_out),   int'(e.alarm),  e.cyc);
                chk("locked_out",  int'(locked_out),  int'(e.locked), e.cyc);
                chk("attempt_rej", int'(attempt_rej), int'(e.rej),    e.cyc);
                chk("fail_count",  int'(fail_count),  int'(e.fc),     e.cyc);
            end
        end
    end

    initial begin : stimulus
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        good();
        idle(10);
        bad();
        idle(1);
        bad();
        idle(1);
        good();
        idle(10);
        bad();
        bad();
        bad();
        idle(5);
        good();
        idle(LOCKOUT_CYCLES);
        good();
        idle(3);
        bad();
        idle(OPEN_CYCLES - 5);
        good();
        idle(2);
        bad();
        bad();
        bad();
        idle(4);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        good();
        idle(OPEN_CYCLES + 1);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        idle(2);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 149) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0,
                 1'($urandom), 1'($urandom));
        end
        idle(2);
        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", q.size(), 0, cyc);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
